// File: rtl/traffic_lamp_monitor.sv
// Lamp decoder and safety monitor behind the four-way light FSM.
// Optional LAMP_TEST_EN adds a lamp_test input that lights all lamps outside FAILSAFE.
module traffic_lamp_monitor #(
  parameter int CONFIRM_CYCLES = 2,
  parameter int WDOG_TICKS     = 8,
  parameter int FLASH_TICKS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] north_in,
  input  logic [1:0] east_in,
  input  logic [1:0] south_in,
  input  logic [1:0] west_in,
  input  logic       fault_clr,
`ifdef LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [2:0] lamp_n,
  output logic [2:0] lamp_e,
  output logic [2:0] lamp_s,
  output logic [2:0] lamp_w,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);

  typedef enum logic [1:0] {
    RUN,
    CONFIRM,
    FAILSAFE
  } state_t;

  state_t          state;
  logic [3:0][1:0] cur;
  logic [3:0][1:0] prev;
  logic [7:0]      wdog;
  logic [7:0]      wdog_nxt;
  logic [3:0]      conf_cnt;
  logic [3:0]      flash_cnt;
  logic            phase;
  logic [2:0]      n_grn;
  logic            v1, v2, v3, v4;
  logic            lvl, chg;
  logic            conf_done;
  logic            go_fail;
  logic            clr_ok;
  logic            flash_wrap;
  logic [2:0]      cause;
  logic            lt_on;
  logic [11:0]     dec_all;

  assign cur = {north_in, east_in, south_in, west_in};

`ifdef LAMP_TEST_EN
  assign lt_on = lamp_test;
`else
  assign lt_on = 1'b0;
`endif

  function automatic logic [2:0] dec(input logic [1:0] c);
    case (c)
      2'b01:   dec = 3'b010;
      2'b10:   dec = 3'b001;
      default: dec = 3'b100;
    endcase
  endfunction

  always_comb begin
    n_grn = '0;
    v2    = 1'b0;
    v3    = 1'b0;
    chg   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_grn = n_grn + {2'b00, cur[i] == 2'b10};
      v2    = v2 | (cur[i] == 2'b11);
      v3    = v3 | (prev[i] == 2'b10 &&
                    cur[i] == 2'b00);
      chg   = chg | (cur[i] != prev[i]);
    end
    v1 = n_grn > 3'd1;
  end

  // An input change beats a coincident tick
  always_comb begin
    wdog_nxt = wdog;
    if (chg)
      wdog_nxt = '0;
    else if (tick && wdog != 8'(WDOG_TICKS))
      wdog_nxt = wdog + 8'd1;
  end

  assign v4  = wdog_nxt == 8'(WDOG_TICKS);
  assign lvl = v1 | v2;

  assign conf_done =
    ({1'b0, conf_cnt} + 5'd1) >= 5'(CONFIRM_CYCLES);
  assign flash_wrap =
    ({1'b0, flash_cnt} + 5'd1) >= 5'(FLASH_TICKS);

  assign go_fail = v3 | v4 | (lvl & conf_done);
  assign clr_ok  = fault_clr & ~(v1 | v2 | v3);

  always_comb begin
    if (v3)      cause = 3'b011;
    else if (v1) cause = 3'b001;
    else if (v2) cause = 3'b010;
    else         cause = 3'b100;
  end

  always_comb begin
    dec_all = {dec(cur[3]), dec(cur[2]),
               dec(cur[1]), dec(cur[0])};
    if (lt_on)
      dec_all = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      {lamp_n, lamp_e, lamp_s, lamp_w} <= {4{3'b100}};
      fault      <= 1'b0;
      fault_code <= 3'b000;
      flash      <= 1'b0;
      prev       <= '0;
      wdog       <= '0;
      conf_cnt   <= '0;
      flash_cnt  <= '0;
      phase      <= 1'b1;
    end else begin
      prev <= cur;
      wdog <= wdog_nxt;
      case (state)
        RUN, CONFIRM: begin
          if (go_fail) begin
            state      <= FAILSAFE;
            {lamp_n, lamp_e, lamp_s, lamp_w} <= {4{3'b100}};
            fault      <= 1'b1;
            fault_code <= cause;
            flash      <= 1'b1;
            flash_cnt  <= '0;
            phase      <= 1'b1;
            conf_cnt   <= '0;
          end else begin
            {lamp_n, lamp_e, lamp_s, lamp_w} <= dec_all;
            if (lvl) begin
              state    <= CONFIRM;
              conf_cnt <= conf_cnt + 4'd1;
            end else begin
              state    <= RUN;
              conf_cnt <= '0;
            end
          end
        end
        default: begin
          if (clr_ok) begin
            state      <= RUN;
            fault      <= 1'b0;
            fault_code <= 3'b000;
            flash      <= 1'b0;
            wdog       <= '0;
            {lamp_n, lamp_e, lamp_s, lamp_w} <= dec_all;
          end else if (tick) begin
            if (flash_wrap) begin
              flash_cnt <= '0;
              phase     <= ~phase;
              {lamp_n, lamp_e, lamp_s, lamp_w} <=
                {4{~phase, 2'b00}};
            end else begin
              flash_cnt <= flash_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/traffic_lamp_monitor.md
Name: traffic_lamp_monitor

Overview:
- Downstream stage of the four-way traffic-light FSM.
- Consumes the FSM's four 2-bit light codes (00 red, 01 yellow, 10 green, 11 illegal) and decodes them into 12 registered one-hot lamp drives.
- Runs a safety conflict monitor in parallel. On a confirmed violation it latches a fault and forces a flashing-red failsafe until an operator clear.

Parameters:
- CONFIRM_CYCLES, 2: consecutive clk cycles a level violation (multi-green, illegal code) must persist before fault; range 1-15.
- WDOG_TICKS, 8: tick pulses without any input change before watchdog fault; range 2-255.
- FLASH_TICKS, 1: tick pulses per half-period of the failsafe red flash; range 1-15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- tick  input  1  one-clk-wide pulse, once per second
- north_in  input  2  north light code
- east_in  input  2  east light code
- south_in  input  2  south light code
- west_in  input  2  west light code
- fault_clr  input  1  operator clear, sampled only in FAILSAFE
- lamp_n  output  3  north lamps {R,Y,G}, one-hot or off
- lamp_e  output  3  east lamps {R,Y,G}
- lamp_s  output  3  south lamps {R,Y,G}
- lamp_w  output  3  west lamps {R,Y,G}
- fault  output  1  latched fault flag
- fault_code  output  3  cause of the latched fault
- flash  output  1  high while in FAILSAFE

Behaviour:
Interface:
- Reset reset, asynchronous, active-high; clock clk.
- All outputs registered.
- Reset values: all lamp_* = 3'b100 (red on), fault=0, fault_code=000, flash=0, state RUN.
- Reset also sets prev-code registers = 00, watchdog count = 0, confirm count = 0, flash phase = 1.

Decode (RUN or CONFIRM states):
- lamp_x = 100/010/001 for code 00/01/10, registered.
- 1-cycle latency: a code change at edge k appears on the lamp at edge k+1.
- Code 11 decodes to 100 (red).

Violation sources, evaluated every clk against the current inputs:
- V1: more than one direction at code 10 (level).
- V2: any direction at code 11 (level).
- V3: any direction whose previous-cycle code was 10 and current code is 00, i.e. green->red without yellow (event).
- V4: watchdog count reaches WDOG_TICKS. The count increments on tick, clears on any change of any input code, and saturates.
- Priority V3 > V1 > V2 > V4.
- fault_code: 001 multi-green, 010 illegal, 011 skipped yellow, 100 watchdog.

State machine RUN / CONFIRM / FAILSAFE:
- RUN: V3 or V4 -> FAILSAFE on the next edge. V1 or V2 -> CONFIRM with confirm count = 1. If CONFIRM_CYCLES = 1, V1 or V2 go directly to FAILSAFE.
- CONFIRM: lamps keep decoding. The same level violation still present -> count+1; when count reaches CONFIRM_CYCLES -> FAILSAFE. Violation gone -> RUN, count cleared. V3 or V4 -> FAILSAFE immediately.
- FAILSAFE entry: fault=1, fault_code latched to the highest-priority cause at entry, flash=1, all Y and G lamps 0, all R lamps 1, flash counter cleared.
- FAILSAFE flashing: every FLASH_TICKS ticks all R lamps toggle together. fault_code is not overwritten by later violations.
- FAILSAFE exit: fault_clr=1 and no V1/V2/V3 in the same cycle -> RUN on the next edge. Exit clears fault, fault_code, flash and the watchdog count. Lamps decode the inputs from that edge onward. fault_clr with an active violation is ignored.
- fault_clr outside FAILSAFE has no effect.
- Prev-code registers update every cycle in all states.
- Simultaneous tick and input change: the change wins, so the watchdog count clears.
- Reset mid-FAILSAFE: immediate return to reset values.

Optional Feature:
- Macro LAMP_TEST_EN.
- Defined: an extra input lamp_test (1 bit) is added. While it is high and the state is not FAILSAFE, all 12 lamps = 1. Monitoring and state continue unaffected. FAILSAFE overrides lamp_test.
- Not defined: no port and no logic; lamps are decoded only.

Test Plan:
- Reset, then drive N=10, E/S/W=00 -> one cycle later lamp_n=001, lamp_e/s/w=100, fault=0.
- Drive N=10 and E=10 for 2 clk -> FAILSAFE: fault=1, fault_code=001, flash=1, all lamps 100. The same stimulus for only 1 clk then cleared -> no fault.
- Drive N 10->00 on consecutive cycles -> FAILSAFE next edge with fault_code=011. A normal sequence N 10->01->00 produces no fault.
- Hold inputs constant for 8 tick pulses -> fault_code=100. One input change before the 8th tick -> no fault.
- In FAILSAFE with FLASH_TICKS=1 -> R lamps toggle each tick. fault_clr with E=11 present is ignored. fault_clr with legal inputs -> RUN, fault=0, fault_code=000.
- Assert reset in FAILSAFE -> all lamps 100, fault=0, flash=0 immediately, without waiting for a clk edge.
